pong_nios_oci_dct_packer: RTL and testbench



---
 rtl/pong_nios_oci_dct_packer_if.sv | 38 +++
 rtl/pong_nios_oci_dct_packer.sv | 121 ++++++++++++
 tb/tb_pong_nios_oci_dct_packer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_nios_oci_dct_packer_if.sv
// Trace-symbol and packed-word bundle for the OCI DCT packer.
// master is the packer's view; dct_drop_count exists only with PONG_NIOS_OCI_DCT_DROP_EN.
interface pong_nios_oci_dct_packer_if;
    logic [1:0]  sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        test_ending;
    logic        test_has_ended;
`ifdef PONG_NIOS_OCI_DCT_DROP_EN
    logic [7:0]  dct_drop_count;

    modport master (
        input  sym_in, sym_valid, dct_ready, test_ending,
        output sym_ready, dct_buffer, dct_count, dct_valid,
        output test_has_ended, dct_drop_count
    );
    modport slave (
        output sym_in, sym_valid, dct_ready, test_ending,
        input  sym_ready, dct_buffer, dct_count, dct_valid,
        input  test_has_ended, dct_drop_count
    );
`else
    modport master (
        input  sym_in, sym_valid, dct_ready, test_ending,
        output sym_ready, dct_buffer, dct_count, dct_valid,
        output test_has_ended
    );
    modport slave (
        output sym_in, sym_valid, dct_ready, test_ending,
        input  sym_ready, dct_buffer, dct_count, dct_valid,
        input  test_has_ended
    );
`endif
endinterface

// File: rtl/pong_nios_oci_dct_packer.sv
// OCI DCT producer: packs 2-bit trace symbols into 30-bit words, drains on test end.
// Optional PONG_NIOS_OCI_DCT_DROP_EN: drop symbols instead of backpressuring when full.
module pong_nios_oci_dct_packer #(
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    pong_nios_oci_dct_packer_if.master bus
);
    localparam int IW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_t;

    state_t      r_state;
    logic [29:0] r_acc_buf;
    logic [3:0]  r_acc_cnt;
    logic [IW-1:0] r_idle;
    logic [29:0] r_buf;
    logic [3:0]  r_cnt;
    logic        r_valid;
    logic        r_ended;

    logic        w_full;
    logic        w_slot_free;
    logic        w_timeout;
    logic        w_flush_req;
    logic        w_xfer;
    logic        w_ready;
    logic        w_store;
    logic [29:0] w_sym_word;

    assign w_full      = (r_acc_cnt == 4'd15);
    assign w_slot_free = !r_valid || bus.dct_ready;
    assign w_timeout   = (FLUSH_TIMEOUT != 0) && (r_idle == IW'(FLUSH_TIMEOUT));
    assign w_flush_req = (r_state == DRAIN) || ((r_state == RUN) && w_timeout);
    assign w_xfer      = w_slot_free &&
                         (w_full || (w_flush_req && (r_acc_cnt != 4'd0)));
    assign w_sym_word  = {28'd0, bus.sym_in};

`ifdef PONG_NIOS_OCI_DCT_DROP_EN
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    assign w_ready = (r_state == RUN);
    assign w_store = bus.sym_valid && w_ready && (!w_full || w_slot_free);
    assign w_drop  = bus.sym_valid && w_ready && w_full && !w_slot_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign bus.dct_drop_count = r_drop_cnt;
`else
    assign w_ready = (r_state == RUN) && (!w_full || w_slot_free);
    assign w_store = bus.sym_valid && w_ready;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_acc_buf <= '0;
            r_acc_cnt <= 4'd0;
            r_idle    <= '0;
            r_buf     <= '0;
            r_cnt     <= 4'd0;
            r_valid   <= 1'b0;
            r_ended   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_buf   <= r_acc_buf;
                r_cnt   <= r_acc_cnt;
                r_valid <= 1'b1;
            end else if (bus.dct_ready) begin
                r_valid <= 1'b0;
            end

            // A symbol landing on a transfer cycle starts the next word at index 0
            if (w_xfer) begin
                r_acc_buf <= w_store ? w_sym_word : '0;
                r_acc_cnt <= w_store ? 4'd1 : 4'd0;
            end else if (w_store) begin
                r_acc_buf <= r_acc_buf | (w_sym_word << {r_acc_cnt, 1'b0});
                r_acc_cnt <= r_acc_cnt + 4'd1;
            end

            if ((r_state != RUN) || w_store || w_xfer || (r_acc_cnt == 4'd0)) begin
                r_idle <= '0;
            end else if (!w_timeout) begin
                r_idle <= r_idle + 1'b1;
            end

            unique case (r_state)
                RUN: begin
                    if (bus.test_ending) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((r_acc_cnt == 4'd0) && !r_valid) begin
                        r_state <= ENDED;
                        r_ended <= 1'b1;
                    end
                end
                ENDED: begin
                    r_ended <= 1'b1;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.sym_ready      = w_ready;
    assign bus.dct_buffer     = r_buf;
    assign bus.dct_count      = r_cnt;
    assign bus.dct_valid      = r_valid;
    assign bus.test_has_ended = r_ended;
endmodule

// File: tb/tb_pong_nios_oci_dct_packer.sv
// Directed bench for the OCI DCT packer: packing, backpressure, timeout, drain, reset.
module tb_pong_nios_oci_dct_packer;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    logic [29:0] q_buf[$];
    logic [3:0]  q_cnt[$];

    pong_nios_oci_dct_packer_if bus();

    pong_nios_oci_dct_packer #(.FLUSH_TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && bus.dct_valid && bus.dct_ready) begin
            q_buf.push_back(bus.dct_buffer);
            q_cnt.push_back(bus.dct_count);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.sym_valid = 1'b0;
        bus.sym_in = 2'd0;
        bus.test_ending = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q_buf.delete();
        q_cnt.delete();
    endtask

    // Offers one symbol until accepted (bounded); returns just after the accepting edge.
    task automatic send(input logic [1:0] s, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            bus.sym_in = s;
            bus.sym_valid = 1'b1;
            #1;
            ok = bus.sym_ready;
            @(posedge clk);
            #1;
            bus.sym_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.dct_ready = 1'b0;
        do_reset();
        @(negedge clk);
        chk("rst_valid", 32'(bus.dct_valid), 32'd0);
        chk("rst_count", 32'(bus.dct_count), 32'd0);
        chk("rst_buffer", 32'(bus.dct_buffer), 32'd0);
        chk("rst_sym_ready", 32'(bus.sym_ready), 32'd1);
        chk("rst_ended", 32'(bus.test_has_ended), 32'd0);
    endtask

    task automatic test_single_word();
        bit ok;
        int acc;
        bus.dct_ready = 1'b1;
        do_reset();
        acc = 0;
        for (int i = 0; i < 15; i++) begin
            send(2'(i % 4), ok);
            if (ok) acc++;
        end
        chk("w1_accepts", 32'(acc), 32'd15);
        @(negedge clk);
        chk("w1_valid_n", 32'(bus.dct_valid), 32'd0);
        @(negedge clk);
        chk("w1_valid_n1", 32'(bus.dct_valid), 32'd1);
        chk("w1_buffer", 32'(bus.dct_buffer), 32'h24E4E4E4);
        chk("w1_count", 32'(bus.dct_count), 32'd15);
        repeat (3) @(negedge clk);
        chk("w1_words", 32'(q_buf.size()), 32'd1);
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc;
        bus.dct_ready = 1'b0;
        do_reset();
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            send(2'b11, ok);
            if (ok) acc++;
        end
        chk("bp_accepts", 32'(acc), 32'd30);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.sym_valid = 1'b1;
            #1;
            chk("bp_sym_ready", 32'(bus.sym_ready), 32'd0);
            chk("bp_hold_buf", 32'(bus.dct_buffer), 32'h3FFFFFFF);
        end
        bus.sym_valid = 1'b0;
        chk("bp_hold_valid", 32'(bus.dct_valid), 32'd1);
        bus.dct_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("bp_words", 32'(q_buf.size()), 32'd2);
        if (q_buf.size() == 2) begin
            chk("bp_word0", 32'(q_buf[0]), 32'h3FFFFFFF);
            chk("bp_word1", 32'(q_buf[1]), 32'h3FFFFFFF);
            chk("bp_cnt0", 32'(q_cnt[0]), 32'd15);
            chk("bp_cnt1", 32'(q_cnt[1]), 32'd15);
        end
        chk("bp_slot_empty", 32'(bus.dct_valid), 32'd0);
    endtask

    task automatic test_timeout();
        bit ok;
        bus.dct_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) send(2'b01, ok);
        repeat (65) @(negedge clk);
        chk("to_not_yet", 32'(bus.dct_valid), 32'd0);
        @(negedge clk);
        chk("to_valid", 32'(bus.dct_valid), 32'd1);
        chk("to_count", 32'(bus.dct_count), 32'd5);
        chk("to_buffer", 32'(bus.dct_buffer), 32'h155);
    endtask

    task automatic test_drain();
        bit ok;
        int wait_cyc;
        logic [1:0] seq[7];
        seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
        bus.dct_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) send(seq[i], ok);
        @(negedge clk);
        bus.sym_in = seq[6];
        bus.sym_valid = 1'b1;
        bus.test_ending = 1'b1;
        #1;
        chk("dr_last_ready", 32'(bus.sym_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
        bus.test_ending = 1'b0;
        wait_cyc = 0;
        while (!bus.test_has_ended && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("dr_ended", 32'(bus.test_has_ended), 32'd1);
        chk("dr_words", 32'(q_buf.size()), 32'd1);
        if (q_buf.size() == 1) begin
            chk("dr_buffer", 32'(q_buf[0]), 32'h1B1B);
            chk("dr_count", 32'(q_cnt[0]), 32'd7);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.sym_valid = 1'b1;
            bus.test_ending = k[0];
            #1;
            chk("dr_no_accept", 32'(bus.sym_ready), 32'd0);
        end
        bus.sym_valid = 1'b0;
        bus.test_ending = 1'b0;
        repeat (3) @(negedge clk);
        chk("dr_sticky", 32'(bus.test_has_ended), 32'd1);
        chk("dr_no_more", 32'(q_buf.size()), 32'd1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.dct_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 24; i++) send(2'b10, ok);
        @(negedge clk);
        chk("rm_pre_valid", 32'(bus.dct_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rm_valid", 32'(bus.dct_valid), 32'd0);
        chk("rm_count", 32'(bus.dct_count), 32'd0);
        chk("rm_buffer", 32'(bus.dct_buffer), 32'd0);
        chk("rm_sym_ready", 32'(bus.sym_ready), 32'd1);
        reset = 1'b0;
        bus.dct_ready = 1'b1;
        repeat (80) @(negedge clk);
        chk("rm_no_word", 32'(q_buf.size()), 32'd0);
    endtask

`ifdef PONG_NIOS_OCI_DCT_DROP_EN
    task automatic test_drop();
        int rdy;
        bus.dct_ready = 1'b0;
        do_reset();
        rdy = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            bus.sym_in = 2'(i % 4);
            bus.sym_valid = 1'b1;
            #1;
            if (bus.sym_ready) rdy++;
            @(posedge clk);
        end
        #1;
        bus.sym_valid = 1'b0;
        @(negedge clk);
        chk("dp_ready_all", 32'(rdy), 32'd35);
        chk("dp_drop_count", 32'(bus.dct_drop_count), 32'd5);
        chk("dp_slot_valid", 32'(bus.dct_valid), 32'd1);
        chk("dp_slot_count", 32'(bus.dct_count), 32'd15);
    endtask
`endif

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.sym_in = 2'd0;
        bus.sym_valid = 1'b0;
        bus.dct_ready = 1'b0;
        bus.test_ending = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_timeout();
        test_drain();
        test_reset_mid();
`ifdef PONG_NIOS_OCI_DCT_DROP_EN
        test_drop();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
